// File: rtl/vin_ctrl_mp.sv
// Video input frame controller: accepts multi-pixel beats, tags each with its
// frame coordinate and line/frame markers, and forwards them through a one-deep output stage.
module vin_ctrl_mp #(
    parameter int unsigned DW  = 16,
    parameter int unsigned PPC = 2,
    parameter int unsigned CW  = 16
) (
    input  logic                vin_clk,
    input  logic                rst_n,
    input  logic                frame_sync_n,
    input  logic [DW*PPC-1:0]   vin_dat,
    input  logic                vin_valid,
    output logic                vin_ready,
    input  logic [CW-1:0]       vin_xres,
    input  logic [CW-1:0]       vin_yres,
    input  logic                wr_ready,
    output logic                wr_valid,
    output logic [CW-1:0]       wr_x,
    output logic [CW-1:0]       wr_y,
    output logic [DW*PPC-1:0]   wr_dat,
    output logic [PPC-1:0]      wr_keep,
    output logic                wr_sof,
    output logic                wr_eol,
    output logic                wr_eof,
    output logic                frame_done,
    output logic                ovf_err,
    output logic                cfg_err
);

    localparam int unsigned XW = CW + 3;

    typedef enum logic [1:0] {
        ARM    = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  xres_q;
    logic [CW-1:0]  yres_q;
    logic [CW-1:0]  x_q;
    logic [CW-1:0]  y_q;
    logic           accept_c;
    logic           load_c;
    logic           discard_c;
    logic           line_end_c;
    logic           eof_c;
    logic           sof_c;
    logic           cfg_bad_c;
    logic [PPC-1:0] keep_c;

    // Beat attributes, evaluated in extended width so x+PPC never wraps
    always_comb begin
        line_end_c = (XW'(x_q) + XW'(PPC)) >= XW'(xres_q);
        eof_c      = line_end_c && (y_q == (yres_q - CW'(1)));
        sof_c      = (x_q == '0) && (y_q == '0);
        cfg_bad_c  = (vin_xres == '0) || (vin_yres == '0);
        keep_c     = '0;
        for (int unsigned i = 0; i < PPC; i++) begin
            keep_c[i] = (XW'(x_q) + XW'(i)) < XW'(xres_q);
        end
    end

    always_ff @(posedge vin_clk) begin
        if (!rst_n) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!frame_sync_n) begin
            state_d = ARM;
        end else begin
            case (state_q)
                ARM:     state_d = cfg_bad_c ? DONE : ACTIVE;
                ACTIVE:  if (load_c && eof_c) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = ARM;
            endcase
        end
    end

    // Input handshake and per-cycle datapath controls
    always_comb begin
        vin_ready = 1'b0;
        case (state_q)
            ACTIVE:  vin_ready = ~wr_valid | wr_ready;
            DONE:    vin_ready = 1'b1;
            default: vin_ready = 1'b0;
        endcase
        if (!rst_n) begin
            vin_ready = 1'b0;
        end
        accept_c  = vin_valid & vin_ready;
        load_c    = accept_c & frame_sync_n & (state_q == ACTIVE);
        discard_c = accept_c & (state_q == DONE);
    end

    // Coordinate tracking, output stage and sticky error flags
    always_ff @(posedge vin_clk) begin
        if (!rst_n) begin
            xres_q     <= '0;
            yres_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            wr_valid   <= 1'b0;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_dat     <= '0;
            wr_keep    <= '0;
            wr_sof     <= 1'b0;
            wr_eol     <= 1'b0;
            wr_eof     <= 1'b0;
            frame_done <= 1'b0;
            ovf_err    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (discard_c) begin
                ovf_err <= 1'b1;
            end
            if (!frame_sync_n) begin
                x_q      <= '0;
                y_q      <= '0;
                wr_valid <= 1'b0;
            end else begin
                if (state_q == ARM) begin
                    xres_q <= vin_xres;
                    yres_q <= vin_yres;
                    if (cfg_bad_c) begin
                        cfg_err <= 1'b1;
                    end
                end
                if (load_c) begin
                    wr_valid <= 1'b1;
                    wr_x     <= x_q;
                    wr_y     <= y_q;
                    wr_dat   <= vin_dat;
                    wr_keep  <= keep_c;
                    wr_sof   <= sof_c;
                    wr_eol   <= line_end_c;
                    wr_eof   <= eof_c;
                    if (line_end_c) begin
                        x_q <= '0;
                        y_q <= y_q + CW'(1);
                    end else begin
                        x_q <= x_q + CW'(PPC);
                    end
                    if (eof_c) begin
                        frame_done <= 1'b1;
                    end
                end else if (wr_ready) begin
                    wr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vin_ctrl_mp.sv
// Directed self-checking bench for vin_ctrl_mp (PPC=2 main instance, PPC=4 partial-beat instance).
module tb_vin_ctrl_mp;

    localparam int unsigned CW = 16;

    logic vin_clk = 1'b0;
    always #5 vin_clk = ~vin_clk;

    logic           rst_n, frame_sync_n;
    logic           vin_valid, vin_ready, wr_ready, wr_valid;
    logic           wr_sof, wr_eol, wr_eof, frame_done, ovf_err, cfg_err;
    logic [31:0]    vin_dat, wr_dat;
    logic [CW-1:0]  vin_xres, vin_yres, wr_x, wr_y;
    logic [1:0]     wr_keep;

    logic           b_valid, b_ready, b_wr_ready, b_wr_valid;
    logic           b_sof, b_eol, b_eof, b_done, b_ovf, b_cfg;
    logic [63:0]    b_dat, b_wr_dat;
    logic [CW-1:0]  b_xres, b_yres, b_x, b_y;
    logic [3:0]     b_keep;

    vin_ctrl_mp #(.DW(16), .PPC(2), .CW(CW)) u_dut (
        .vin_clk(vin_clk), .rst_n(rst_n), .frame_sync_n(frame_sync_n),
        .vin_dat(vin_dat), .vin_valid(vin_valid), .vin_ready(vin_ready),
        .vin_xres(vin_xres), .vin_yres(vin_yres), .wr_ready(wr_ready),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_dat(wr_dat),
        .wr_keep(wr_keep), .wr_sof(wr_sof), .wr_eol(wr_eol), .wr_eof(wr_eof),
        .frame_done(frame_done), .ovf_err(ovf_err), .cfg_err(cfg_err)
    );

    vin_ctrl_mp #(.DW(16), .PPC(4), .CW(CW)) u_dut4 (
        .vin_clk(vin_clk), .rst_n(rst_n), .frame_sync_n(frame_sync_n),
        .vin_dat(b_dat), .vin_valid(b_valid), .vin_ready(b_ready),
        .vin_xres(b_xres), .vin_yres(b_yres), .wr_ready(b_wr_ready),
        .wr_valid(b_wr_valid), .wr_x(b_x), .wr_y(b_y), .wr_dat(b_wr_dat),
        .wr_keep(b_keep), .wr_sof(b_sof), .wr_eol(b_eol), .wr_eof(b_eof),
        .frame_done(b_done), .ovf_err(b_ovf), .cfg_err(b_cfg)
    );

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [1:0]    keep;
        logic          sof;
        logic          eol;
        logic          eof;
        logic [31:0]   dat;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkdat(input int k);
        return {16'(32'hA000 + 2 * k + 1), 16'(32'hA000 + 2 * k)};
    endfunction

    // Record every output handshake, sampled mid-cycle
    always @(negedge vin_clk) begin
        #2;
        if (wr_valid && wr_ready) begin
            q.push_back('{x: wr_x, y: wr_y, keep: wr_keep, sof: wr_sof,
                          eol: wr_eol, eof: wr_eof, dat: wr_dat});
        end
    end

    task automatic send(input logic [31:0] d);
        int n = 0;
        @(negedge vin_clk);
        vin_valid = 1'b1;
        vin_dat   = d;
        #1;
        while (!vin_ready && n < 20) begin
            @(negedge vin_clk);
            #1;
            n++;
        end
        if (!vin_ready) check("send_timeout", 64'(vin_ready), 64'd1);
        @(posedge vin_clk);
    endtask

    task automatic idle();
        @(negedge vin_clk);
        vin_valid = 1'b0;
        #3;
    endtask

    task automatic restart();
        @(negedge vin_clk);
        vin_valid    = 1'b0;
        frame_sync_n = 1'b0;
        @(negedge vin_clk);
        frame_sync_n = 1'b1;
        @(posedge vin_clk);
    endtask

    // Six-beat 6x2 frame with data mkdat(base..base+5)
    task automatic check_frame(input int base);
        check("frame_beats", 64'(q.size()), 64'd6);
        for (int k = 0; k < 6 && k < q.size(); k++) begin
            check($sformatf("beat%0d_x", k), 64'(q[k].x), 64'((k % 3) * 2));
            check($sformatf("beat%0d_y", k), 64'(q[k].y), 64'(k / 3));
            check($sformatf("beat%0d_flags", k), 64'({q[k].keep, q[k].sof, q[k].eol, q[k].eof}),
                  64'({2'b11, k == 0, (k == 2) || (k == 5), k == 5}));
            check($sformatf("beat%0d_dat", k), 64'(q[k].dat), 64'(mkdat(base + k)));
        end
        q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; frame_sync_n = 1'b1; vin_valid = 1'b0; vin_dat = '0;
        wr_ready = 1'b1; vin_xres = 16'd6; vin_yres = 16'd2;
        b_valid = 1'b0; b_dat = '0; b_wr_ready = 1'b1; b_xres = 16'd6; b_yres = 16'd1;

        repeat (2) @(negedge vin_clk);
        #3;
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_vin_ready", 64'(vin_ready), 64'd0);
        check("rst_wr_x", 64'(wr_x), 64'd0);
        check("rst_flags", 64'({wr_sof, wr_eol, wr_eof, frame_done, ovf_err, cfg_err}), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        rst_n = 1'b1;

        // Partial last beat, PPC=4, xres=6, yres=1
        @(negedge vin_clk);
        b_valid = 1'b1;
        b_dat   = 64'h4444_3333_2222_1111;
        #1;
        check("b_ready", 64'(b_ready), 64'd1);
        @(negedge vin_clk);
        b_dat = 64'h8888_7777_6666_5555;
        #3;
        check("b1_valid", 64'(b_wr_valid), 64'd1);
        check("b1_x_keep", 64'({b_x, b_keep}), 64'({16'd0, 4'b1111}));
        check("b1_flags", 64'({b_sof, b_eol, b_eof}), 64'b100);
        check("b1_dat", b_wr_dat, 64'h4444_3333_2222_1111);
        @(negedge vin_clk);
        b_valid = 1'b0;
        #3;
        check("b2_x_keep", 64'({b_x, b_keep}), 64'({16'd4, 4'b0011}));
        check("b2_flags", 64'({b_sof, b_eol, b_eof}), 64'b011);
        check("b2_dat", b_wr_dat, 64'h8888_7777_6666_5555);
        check("b_done", 64'(b_done), 64'd1);
        @(negedge vin_clk);
        #3;
        check("b_done_pulse", 64'(b_done), 64'd0);
        check("b_wr_valid_clr", 64'(b_wr_valid), 64'd0);

        // Nominal 6x2 frame
        q.delete();
        restart();
        for (int k = 0; k < 6; k++) send(mkdat(k));
        idle();
        check("nom_frame_done", 64'(frame_done), 64'd1);
        check("nom_eof", 64'({wr_valid, wr_eof}), 64'b11);
        @(negedge vin_clk);
        #3;
        check("nom_done_pulse", 64'(frame_done), 64'd0);
        check_frame(0);

        // Overflow: two beats after eof
        check("ovf_before", 64'(ovf_err), 64'd0);
        send(mkdat(20));
        send(mkdat(21));
        idle();
        check("ovf_wr_valid", 64'(wr_valid), 64'd0);
        check("ovf_err", 64'(ovf_err), 64'd1);
        check("ovf_no_beats", 64'(q.size()), 64'd0);

        // Backpressure for 3 cycles after the first beat
        restart();
        send(mkdat(10));
        @(negedge vin_clk);
        wr_ready = 1'b0;
        vin_dat  = mkdat(11);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_vin_ready", 64'(vin_ready), 64'd0);
            check("bp_hold", 64'({wr_valid, wr_x, wr_dat}), 64'({1'b1, 16'd0, mkdat(10)}));
            @(negedge vin_clk);
        end
        wr_ready = 1'b1;
        @(posedge vin_clk);
        for (int k = 12; k < 16; k++) send(mkdat(k));
        idle();
        check_frame(10);

        // Frame restart with a beat pending at (2,0) and next coordinate (4,0)
        restart();
        send(mkdat(30));
        send(mkdat(31));
        @(negedge vin_clk);
        vin_valid = 1'b0; wr_ready = 1'b0; frame_sync_n = 1'b0;
        @(negedge vin_clk);
        frame_sync_n = 1'b1; wr_ready = 1'b1;
        #3;
        check("rs_dropped", 64'(wr_valid), 64'd0);
        check("rs_arm_ready", 64'(vin_ready), 64'd0);
        @(posedge vin_clk);
        send(mkdat(40));
        idle();
        check("rs_coord", 64'({wr_x, wr_y}), 64'd0);
        check("rs_sof", 64'({wr_valid, wr_sof}), 64'b11);
        check("rs_dat", 64'(wr_dat), 64'(mkdat(40)));
        check("rs_beats", 64'(q.size()), 64'd2);
        if (q.size() == 2) begin
            check("rs_beat0", 64'(q[0].dat), 64'(mkdat(30)));
            check("rs_beat1", 64'(q[1].dat), 64'(mkdat(40)));
        end
        q.delete();

        // Bad configuration: xres=0
        vin_xres = 16'd0;
        restart();
        send(mkdat(50));
        idle();
        check("cfg_err", 64'(cfg_err), 64'd1);
        check("cfg_no_valid", 64'(wr_valid), 64'd0);
        check("cfg_no_beats", 64'(q.size()), 64'd0);
        vin_xres = 16'd6;
        restart();
        #1;
        check("cfg_sticky", 64'({cfg_err, ovf_err}), 64'b11);

        // Reset with a pending beat
        send(mkdat(60));
        @(negedge vin_clk);
        vin_valid = 1'b0; wr_ready = 1'b0;
        #3;
        check("pend_valid", 64'(wr_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge vin_clk);
        #3;
        check("rst2_wr", 64'({wr_valid, wr_x, wr_y, wr_keep}), 64'd0);
        check("rst2_dat", 64'(wr_dat), 64'd0);
        check("rst2_err", 64'({ovf_err, cfg_err, frame_done}), 64'd0);
        check("rst2_ready", 64'(vin_ready), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vin_ctrl_mp.md
VIN_CTRL_MP -- requirements
Module: vin_ctrl_mp

Interface
REQ-001 SHALL have parameter DW, default 16: bits per pixel.
REQ-002 SHALL have parameter PPC, default 2: pixels per beat (1..4).
REQ-003 SHALL have parameter CW, default 16: coordinate and resolution width.
REQ-004 SHALL have port vin_clk  in  1: the single clock; all logic rises on it.
REQ-005 SHALL have port rst_n  in  1: reset, synchronous and active-low.
REQ-006 SHALL have port frame_sync_n  in  1: active-low frame restart, synchronous.
REQ-007 SHALL have port vin_dat  in  DW*PPC: pixel lane i in bits [i*DW +: DW].
REQ-008 SHALL have port vin_valid  in  1: input beat valid.
REQ-009 SHALL have port vin_ready  out  1: input beat accepted when vin_valid and vin_ready are both high.
REQ-010 SHALL have ports vin_xres and vin_yres  in  CW each: frame width and height in pixels.
REQ-011 SHALL have port wr_ready  in  1: downstream accepts the output beat.
REQ-012 SHALL have port wr_valid  out  1: output beat valid.
REQ-013 SHALL have ports wr_x and wr_y  out  CW each: coordinate of lane 0.
REQ-014 SHALL have port wr_dat  out  DW*PPC: pixel data.
REQ-015 SHALL have port wr_keep  out  PPC: lane i is valid when wr_x+i < xres.
REQ-016 SHALL have ports wr_sof and wr_eol  out  1 each: first beat of the frame, last beat of the line.
REQ-017 SHALL have port wr_eof  out  1: last beat of the frame.
REQ-018 SHALL have port frame_done  out  1: one-cycle pulse.
REQ-019 SHALL have ports ovf_err and cfg_err  out  1 each: sticky error flags.

Function
REQ-020 SHALL implement FSM states ARM, ACTIVE and DONE.
REQ-021 SHALL leave ARM for ACTIVE on the first cycle frame_sync_n=1, latching xres and yres.
REQ-022 SHALL, if either latched value is 0, go from ARM to DONE instead and set cfg_err.
REQ-023 SHALL ignore vin_xres and vin_yres changes made while in ACTIVE.
REQ-024 SHALL hold vin_ready at 0 in ARM.
REQ-025 SHALL set vin_ready = ~wr_valid | wr_ready in ACTIVE, combinationally.
REQ-026 SHALL hold vin_ready at 1 in DONE, so excess input is drained.
REQ-027 SHALL register an accepted beat into the output stage, appearing one cycle later (latency 1).
REQ-028 SHALL hold the output stage stable while wr_valid=1 and wr_ready=0.
REQ-029 SHALL clear wr_valid on the cycle after a wr_valid and wr_ready handshake with no new accept.
REQ-030 SHALL, on each accepted beat, record coordinate (x,y) then advance it.
REQ-031 SHALL compute the line-end condition as x+PPC >= xres, in CW+3 bits with no wrap.
REQ-032 SHALL, at line end, set x to 0 and increment y; otherwise x advances by PPC.
REQ-033 SHALL assert wr_sof when the recorded coordinate is (0,0) on the first accepted beat.
REQ-034 SHALL assert wr_eol on the line-end beat.
REQ-035 SHALL assert wr_eof on the line-end beat with y = yres-1.
REQ-036 SHALL, when accepting the wr_eof beat, enter DONE and pulse frame_done on the following cycle.
REQ-037 SHALL discard accepted beats in DONE, never setting wr_valid for them.
REQ-038 SHALL set ovf_err on the first beat discarded in DONE.
REQ-039 SHALL stay in DONE until frame_sync_n=0.
REQ-040 SHALL, when frame_sync_n=0 in any state, enter ARM and clear x, y and wr_valid on the next edge, dropping any pending beat.
REQ-041 SHALL keep ovf_err and cfg_err across frame_sync_n; only rst_n clears them.
REQ-042 SHALL give rst_n priority when rst_n and frame_sync_n are low together.
REQ-043 SHALL leave wr_keep lanes beyond xres with their data passed through unmodified.

Reset
REQ-044 SHALL, with rst_n=0 at a clock edge, enter ARM with all of these at 0: x, y, wr_valid, wr_x, wr_y, wr_dat, wr_keep, wr_sof, wr_eol, wr_eof, frame_done, ovf_err, cfg_err.
REQ-045 SHALL drive vin_ready to 0 during reset.
REQ-046 SHALL, on reset mid-frame, discard the pending output beat without a handshake.

Verification
REQ-047 SHALL cover the nominal frame: PPC=2, xres=6, yres=2, wr_ready=1, 6 beats -> wr_x 0,2,4,0,2,4, wr_y 0,0,0,1,1,1, eol on beats 3 and 6, sof on beat 1 only, eof on beat 6, frame_done one cycle later.
REQ-048 SHALL cover a partial last beat: PPC=4, xres=6, yres=1 -> beat 1 keep=1111, beat 2 wr_x=4 keep=0011 with eol and eof.
REQ-049 SHALL cover backpressure: wr_ready=0 for 3 cycles mid-line -> vin_ready=0 and wr_* frozen; no beat lost or duplicated; coordinates continuous after release.
REQ-050 SHALL cover overflow: 2 extra beats after eof -> both accepted, wr_valid stays 0, ovf_err=1.
REQ-051 SHALL cover frame restart: frame_sync_n pulsed low for 1 cycle at (4,0) -> next frame starts at wr_x=0, wr_y=0 with sof; the pending beat is dropped.
REQ-052 SHALL cover bad configuration: xres=0 latched -> cfg_err=1, FSM in DONE, no wr_valid output.
